// File: rtl/usb_ep_pkg.sv
// Shared sizing defaults for the USB endpoint buffer bank and its FIFOs.
package usb_ep_pkg;

  localparam int EP_ADDR_WID_DFLT = 9;
  localparam int EP_DATA_WID_DFLT = 8;
  localparam int EP_PTR_WID_DFLT  = EP_ADDR_WID_DFLT + 1;

endpackage

// File: rtl/usb_trans_fifo.sv
// Single FIFO with transactional write and read sides: speculative pointers
// advance per word, committed pointers move only on a successful TransDone.
module usb_trans_fifo
  import usb_ep_pkg::*;
#(
  parameter int ADDR_WID = EP_ADDR_WID_DFLT,
  parameter int DATA_WID = EP_DATA_WID_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrEn,
  input  logic [DATA_WID-1:0] wrData,
  input  logic                wrTransDone,
  input  logic                wrTransSuccess,
  input  logic                rdEn,
  input  logic                rdTransDone,
  input  logic                rdTransSuccess,
  output logic [DATA_WID-1:0] rdData,
  output logic                full,
  output logic                empty
);

  localparam int PTR_WID = ADDR_WID + 1;
  localparam int DEPTH   = 1 << ADDR_WID;

  logic [PTR_WID-1:0]  wrSpec, wrCommit, rdSpec, rdCommit;
  logic [PTR_WID-1:0]  wrSpecInc, rdSpecInc;
  logic                wrAccept, rdAccept;
  logic [DATA_WID-1:0] mem [DEPTH];

  // Producer only sees space freed by committed reads; consumer only sees
  // words the producer has committed.
  assign full  = (wrSpec[PTR_WID-1] != rdCommit[PTR_WID-1]) &&
                 (wrSpec[ADDR_WID-1:0] == rdCommit[ADDR_WID-1:0]);
  assign empty = (rdSpec == wrCommit);

  assign wrAccept  = wrEn & ~full;
  assign rdAccept  = rdEn & ~empty;
  assign wrSpecInc = wrSpec + {{ADDR_WID{1'b0}}, wrAccept};
  assign rdSpecInc = rdSpec + {{ADDR_WID{1'b0}}, rdAccept};

  assign rdData = mem[rdSpec[ADDR_WID-1:0]];

  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wrSpec[ADDR_WID-1:0]] <= wrData;
    end
  end

  // A word moved in the same cycle as TransDone belongs to that transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrSpec   <= '0;
      wrCommit <= '0;
    end else if (wrTransDone) begin
      if (wrTransSuccess) begin
        wrSpec   <= wrSpecInc;
        wrCommit <= wrSpecInc;
      end else begin
        wrSpec   <= wrCommit;
      end
    end else begin
      wrSpec <= wrSpecInc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdSpec   <= '0;
      rdCommit <= '0;
    end else if (rdTransDone) begin
      if (rdTransSuccess) begin
        rdSpec   <= rdSpecInc;
        rdCommit <= rdSpecInc;
      end else begin
        rdSpec   <= rdCommit;
      end
    end else begin
      rdSpec <= rdSpecInc;
    end
  end

endmodule

// File: rtl/usb_ep_buffer_bank.sv
// Per-endpoint IN and OUT buffering between the USB protocol engine and the
// application; each channel owns one transactional FIFO per direction.
module usb_ep_buffer_bank
  import usb_ep_pkg::*;
#(
  parameter int ENDPOINTS   = 1,
  parameter int EP_ADDR_WID = EP_ADDR_WID_DFLT,
  parameter int EP_DATA_WID = EP_DATA_WID_DFLT
) (
  input  logic                             clk48,
  input  logic                             rst,
  input  logic [ENDPOINTS-1:0]             EP_IN_popData,
  input  logic [ENDPOINTS-1:0]             EP_IN_popTransDone,
  input  logic [ENDPOINTS-1:0]             EP_IN_popTransSuccess,
  output logic [ENDPOINTS-1:0]             EP_IN_dataAvailable,
  output logic [EP_DATA_WID*ENDPOINTS-1:0] EP_IN_dataOut,
  input  logic [ENDPOINTS-1:0]             EP_OUT_dataValid,
  input  logic [ENDPOINTS-1:0]             EP_OUT_fillTransDone,
  input  logic [ENDPOINTS-1:0]             EP_OUT_fillTransSuccess,
  output logic [ENDPOINTS-1:0]             EP_OUT_full,
  input  logic [EP_DATA_WID*ENDPOINTS-1:0] EP_OUT_dataIn,
  input  logic [ENDPOINTS-1:0]             APP_IN_push,
  input  logic [EP_DATA_WID*ENDPOINTS-1:0] APP_IN_data,
  output logic [ENDPOINTS-1:0]             APP_IN_full,
  input  logic [ENDPOINTS-1:0]             APP_OUT_pop,
  output logic [EP_DATA_WID*ENDPOINTS-1:0] APP_OUT_data,
  output logic [ENDPOINTS-1:0]             APP_OUT_empty
);

  // Handshake: a push/dataValid transfers a word only in a cycle where the
  // matching full flag is low; a pop transfers only where empty/unavailable
  // is low. Requests against a blocked flag are dropped, never queued. Flags
  // come straight from registered pointers, so they never depend on inputs
  // in the same cycle.
  for (genvar i = 0; i < ENDPOINTS; i++) begin : gCh
    logic inEmpty;

    usb_trans_fifo #(
      .ADDR_WID(EP_ADDR_WID),
      .DATA_WID(EP_DATA_WID)
    ) uOutFifo (
      .clk            (clk48),
      .rst            (rst),
      .wrEn           (EP_OUT_dataValid[i]),
      .wrData         (EP_OUT_dataIn[i*EP_DATA_WID +: EP_DATA_WID]),
      .wrTransDone    (EP_OUT_fillTransDone[i]),
      .wrTransSuccess (EP_OUT_fillTransSuccess[i]),
      .rdEn           (APP_OUT_pop[i]),
      .rdTransDone    (1'b1),
      .rdTransSuccess (1'b1),
      .rdData         (APP_OUT_data[i*EP_DATA_WID +: EP_DATA_WID]),
      .full           (EP_OUT_full[i]),
      .empty          (APP_OUT_empty[i])
    );

    usb_trans_fifo #(
      .ADDR_WID(EP_ADDR_WID),
      .DATA_WID(EP_DATA_WID)
    ) uInFifo (
      .clk            (clk48),
      .rst            (rst),
      .wrEn           (APP_IN_push[i]),
      .wrData         (APP_IN_data[i*EP_DATA_WID +: EP_DATA_WID]),
      .wrTransDone    (1'b1),
      .wrTransSuccess (1'b1),
      .rdEn           (EP_IN_popData[i]),
      .rdTransDone    (EP_IN_popTransDone[i]),
      .rdTransSuccess (EP_IN_popTransSuccess[i]),
      .rdData         (EP_IN_dataOut[i*EP_DATA_WID +: EP_DATA_WID]),
      .full           (APP_IN_full[i]),
      .empty          (inEmpty)
    );

    assign EP_IN_dataAvailable[i] = ~inEmpty;
  end

endmodule

// File: tb/tb_usb_ep_buffer_bank.sv
// Directed and randomized checks of the endpoint buffer bank against a
// queue-based packet model of the IN and OUT channels.
module tb_usb_ep_buffer_bank;

  localparam int E  = 2;
  localparam int AW = 2;
  localparam int W  = 8;
  localparam int D  = 1 << AW;

  logic           clk48 = 1'b0;
  logic           rst;
  logic [E-1:0]   epInPop, epInDone, epInSucc, epInAvail;
  logic [W*E-1:0] epInDataOut;
  logic [E-1:0]   epOutValid, epOutDone, epOutSucc, epOutFull;
  logic [W*E-1:0] epOutDataIn;
  logic [E-1:0]   appInPush, appInFull;
  logic [W*E-1:0] appInData;
  logic [E-1:0]   appOutPop, appOutEmpty;
  logic [W*E-1:0] appOutData;

  // Model: committed/pending OUT words, IN words not yet freed, IN words sent.
  logic [W-1:0] outComQ [E][$];
  logic [W-1:0] outPendQ[E][$];
  logic [W-1:0] inQ     [E][$];
  int           inSent  [E];

  int nVec = 0;
  int nMis = 0;

  always #10 clk48 = ~clk48;

  usb_ep_buffer_bank #(
    .ENDPOINTS(E), .EP_ADDR_WID(AW), .EP_DATA_WID(W)
  ) dut (
    .clk48                  (clk48),
    .rst                    (rst),
    .EP_IN_popData          (epInPop),
    .EP_IN_popTransDone     (epInDone),
    .EP_IN_popTransSuccess  (epInSucc),
    .EP_IN_dataAvailable    (epInAvail),
    .EP_IN_dataOut          (epInDataOut),
    .EP_OUT_dataValid       (epOutValid),
    .EP_OUT_fillTransDone   (epOutDone),
    .EP_OUT_fillTransSuccess(epOutSucc),
    .EP_OUT_full            (epOutFull),
    .EP_OUT_dataIn          (epOutDataIn),
    .APP_IN_push            (appInPush),
    .APP_IN_data            (appInData),
    .APP_IN_full            (appInFull),
    .APP_OUT_pop            (appOutPop),
    .APP_OUT_data           (appOutData),
    .APP_OUT_empty          (appOutEmpty)
  );

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkByte(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    epInPop = '0; epInDone = '0; epInSucc = '0;
    epOutValid = '0; epOutDone = '0; epOutSucc = '0; epOutDataIn = '0;
    appInPush = '0; appInData = '0; appOutPop = '0;
  endtask

  // Advance the model by one clock using pre-edge model state as the flags.
  task automatic stepModel();
    for (int c = 0; c < E; c++) begin
      bit outFullM, outEmptyM, inFullM, availM;
      outFullM  = (outComQ[c].size() + outPendQ[c].size()) == D;
      outEmptyM = outComQ[c].size() == 0;
      inFullM   = inQ[c].size() == D;
      availM    = inSent[c] < inQ[c].size();
      if (rst) begin
        outComQ[c].delete(); outPendQ[c].delete(); inQ[c].delete(); inSent[c] = 0;
      end else begin
        if (appOutPop[c] && !outEmptyM) void'(outComQ[c].pop_front());
        if (epOutValid[c] && !outFullM) outPendQ[c].push_back(epOutDataIn[c*W +: W]);
        if (epOutDone[c]) begin
          if (epOutSucc[c]) begin
            while (outPendQ[c].size() > 0) outComQ[c].push_back(outPendQ[c].pop_front());
          end else begin
            outPendQ[c].delete();
          end
        end
        if (appInPush[c] && !inFullM) inQ[c].push_back(appInData[c*W +: W]);
        if (epInPop[c] && availM) inSent[c]++;
        if (epInDone[c]) begin
          if (epInSucc[c]) repeat (inSent[c]) void'(inQ[c].pop_front());
          inSent[c] = 0;
        end
      end
    end
  endtask

  task automatic checkAll();
    for (int c = 0; c < E; c++) begin
      chkBit($sformatf("appOutEmpty[%0d]", c), appOutEmpty[c], outComQ[c].size() == 0);
      chkBit($sformatf("epOutFull[%0d]", c), epOutFull[c],
             (outComQ[c].size() + outPendQ[c].size()) == D);
      chkBit($sformatf("appInFull[%0d]", c), appInFull[c], inQ[c].size() == D);
      chkBit($sformatf("epInAvail[%0d]", c), epInAvail[c], inSent[c] < inQ[c].size());
      if (outComQ[c].size() > 0)
        chkByte($sformatf("appOutData[%0d]", c), appOutData[c*W +: W], outComQ[c][0]);
      if (inSent[c] < inQ[c].size())
        chkByte($sformatf("epInDataOut[%0d]", c), epInDataOut[c*W +: W], inQ[c][inSent[c]]);
    end
  endtask

  task automatic cycle();
    stepModel();
    @(posedge clk48);
    #1;
    checkAll();
    idle();
  endtask

  initial begin
    logic [W-1:0] vals[3];
    logic [W-1:0] b;
    vals = '{8'h11, 8'h22, 8'h33};
    for (int c = 0; c < E; c++) inSent[c] = 0;
    idle();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    chkBit("rstAvail", epInAvail[0], 1'b0);
    chkBit("rstOutFull", epOutFull[1], 1'b0);
    chkBit("rstInFull", appInFull[0], 1'b0);
    chkBit("rstOutEmpty", appOutEmpty[1], 1'b1);

    // OUT commit on channel 1, channel 0 untouched.
    for (int k = 0; k < 3; k++) begin
      epOutValid[1] = 1'b1; epOutDataIn[W +: W] = vals[k]; cycle();
      chkBit("out1PreCommitEmpty", appOutEmpty[1], 1'b1);
    end
    epOutDone[1] = 1'b1; epOutSucc[1] = 1'b1; cycle();
    chkBit("out1CommitEmpty", appOutEmpty[1], 1'b0);
    chkBit("out0Untouched", appOutEmpty[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      chkByte("out1PopData", appOutData[W +: W], vals[k]);
      appOutPop[1] = 1'b1; cycle();
    end
    chkBit("out1Drained", appOutEmpty[1], 1'b1);

    // OUT rollback, then a one-word packet committed in the same cycle as its word.
    epOutValid[0] = 1'b1; epOutDataIn[0 +: W] = 8'hAA; cycle();
    epOutValid[0] = 1'b1; epOutDataIn[0 +: W] = 8'hBB; cycle();
    epOutDone[0] = 1'b1; epOutSucc[0] = 1'b0; cycle();
    chkBit("rollbackEmpty", appOutEmpty[0], 1'b1);
    epOutValid[0] = 1'b1; epOutDataIn[0 +: W] = 8'hCC;
    epOutDone[0] = 1'b1; epOutSucc[0] = 1'b1; cycle();
    chkBit("sameCycleEmpty", appOutEmpty[0], 1'b0);
    chkByte("sameCycleData", appOutData[0 +: W], 8'hCC);
    appOutPop[0] = 1'b1; cycle();

    // IN replay after a failed transaction.
    for (int k = 1; k <= 4; k++) begin
      appInPush[0] = 1'b1; appInData[0 +: W] = W'(k); cycle();
    end
    chkBit("inFullAfter4", appInFull[0], 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chkByte("inFirstPass", epInDataOut[0 +: W], W'(k));
      epInPop[0] = 1'b1; cycle();
    end
    chkBit("inAllSent", epInAvail[0], 1'b0);
    epInDone[0] = 1'b1; epInSucc[0] = 1'b0; cycle();
    chkBit("inReplayAvail", epInAvail[0], 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chkByte("inReplay", epInDataOut[0 +: W], W'(k));
      epInPop[0] = 1'b1; cycle();
    end
    epInDone[0] = 1'b1; epInSucc[0] = 1'b1; cycle();
    chkBit("inAckAvail", epInAvail[0], 1'b0);
    chkBit("inAckFull", appInFull[0], 1'b0);

    // Full boundary and pointer wrap over three rounds.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        epOutValid[1] = 1'b1; epOutDataIn[W +: W] = W'(8'h40 + r * 16 + k); cycle();
        if (k == 3) chkBit("fullAfter4", epOutFull[1], 1'b1);
      end
      epOutDone[1] = 1'b1; epOutSucc[1] = 1'b1; cycle();
      for (int k = 0; k < 4; k++) begin
        chkByte("wrapData", appOutData[W +: W], W'(8'h40 + r * 16 + k));
        appOutPop[1] = 1'b1; cycle();
      end
      chkBit("wrapEmpty", appOutEmpty[1], 1'b1);
      chkBit("wrapNotFull", epOutFull[1], 1'b0);
    end

    // Reset in the middle of OUT and IN transactions.
    epOutValid[0] = 1'b1; epOutDataIn[0 +: W] = 8'h5A; appInPush[1] = 1'b1; appInData[W +: W] = 8'hA5; cycle();
    epInPop[1] = 1'b1; epOutValid[0] = 1'b1; epOutDataIn[0 +: W] = 8'h5B; cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chkBit("midRstOutEmpty", appOutEmpty[0], 1'b1);
    chkBit("midRstAvail", epInAvail[1], 1'b0);
    chkBit("midRstOutFull", epOutFull[0], 1'b0);
    epOutDone[0] = 1'b1; epOutSucc[0] = 1'b1; cycle();
    chkBit("midRstNoStale", appOutEmpty[0], 1'b1);

    // Randomized traffic on both channels.
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < E; c++) begin
        epOutValid[c] = ($urandom_range(0, 1) == 1);
        b = W'($urandom); epOutDataIn[c*W +: W] = b;
        epOutDone[c]  = ($urandom_range(0, 5) == 0);
        epOutSucc[c]  = ($urandom_range(0, 3) != 0);
        appOutPop[c]  = ($urandom_range(0, 2) == 0);
        appInPush[c]  = ($urandom_range(0, 1) == 1);
        b = W'($urandom); appInData[c*W +: W] = b;
        epInPop[c]    = ($urandom_range(0, 2) == 0);
        epInDone[c]   = ($urandom_range(0, 5) == 0);
        epInSucc[c]   = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
